// File: rtl/spi_arb_pkg.sv
// Shared types and default constants for the SPI burst arbiter.
// SPI_ARB_TIMEOUT_EN adds the default per-byte watchdog limit.
package spi_arb_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_BITS_SIZE = 8;
  localparam int DEF_LEN_W     = 4;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int DEF_TIMEOUT_CYCLES = 4096;
`endif

  // Burst sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    RELEASE
  } state_t;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: returns the first requester at or after
// the priority pointer, wrapping around, plus a valid flag.
module spi_rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Scan from the farthest offset down so the nearest requester wins.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NUM_REQ]) begin
        idx   = IDX_W'((int'(ptr) + i) % NUM_REQ);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin sharing of one single-byte SPI master among NUM_REQ
// requesters, sequencing multi-byte bursts under a per-requester chip-select.
// Optional feature macro: SPI_ARB_TIMEOUT_EN (per-byte watchdog driving err
// and m_abort_n; without it err is tied 0 and m_abort_n tied 1).
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int BITS_SIZE = DEF_BITS_SIZE,
  parameter int LEN_W     = DEF_LEN_W
`ifdef SPI_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*LEN_W-1:0]     req_len,
  input  logic [NUM_REQ*BITS_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           data_ack,
  output logic [BITS_SIZE-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [NUM_REQ-1:0]           cs_n,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic [BITS_SIZE-1:0]         m_data_in,
  output logic                         m_tx_start,
  input  logic                         m_tx_done,
  input  logic [BITS_SIZE-1:0]         m_data_out,
  output logic                         err,
  output logic                         m_abort_n
);

  localparam int IDX_W = $clog2(NUM_REQ);
  // Byte counter holds req_len + 1, so it needs one extra bit.
  localparam int CNT_W = LEN_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;

  spi_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req  (req),
    .ptr  (ptr),
    .idx  (pick_idx),
    .valid(pick_valid)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
`else
  assign err       = 1'b0;
  assign m_abort_n = 1'b1;
`endif

  // Burst sequencer: arbitration, byte hand-off to the master, response
  // return and release, with all outputs registered.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      count      <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      cs_n       <= '1;
      data_ack   <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      m_data_in  <= '0;
      m_tx_start <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      to_cnt     <= '0;
      err        <= 1'b0;
      m_abort_n  <= 1'b1;
`endif
    end else begin
      // Pulse outputs fall back to idle unless a state raises them.
      data_ack   <= '0;
      rsp_valid  <= '0;
      m_tx_start <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      err        <= 1'b0;
      m_abort_n  <= 1'b1;
`endif
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id <= pick_idx;
            count    <= CNT_W'(req_len[pick_idx*LEN_W +: LEN_W]) + CNT_ONE;
            busy     <= 1'b1;
            cs_n     <= ~(NUM_REQ'(1) << pick_idx);
            state    <= LOAD;
          end
        end

        LOAD: begin
          m_data_in <= req_data[grant_id*BITS_SIZE +: BITS_SIZE];
          data_ack  <= NUM_REQ'(1) << grant_id;
          state     <= START;
        end

        START: begin
          m_tx_start <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
          to_cnt     <= '0;
`endif
          state      <= WAIT;
        end

        WAIT: begin
          // The master still shows the previous byte's done level while the
          // start pulse is out; it only clears on the start edge.
          if (m_tx_done && !m_tx_start) begin
            rsp_data  <= m_data_out;
            rsp_valid <= NUM_REQ'(1) << grant_id;
            count     <= count - CNT_ONE;
            state     <= (count == CNT_ONE) ? RELEASE : LOAD;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            err       <= 1'b1;
            m_abort_n <= 1'b0;
            state     <= RELEASE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end

        RELEASE: begin
          cs_n  <= '1;
          busy  <= 1'b0;
          // The requester just served drops to lowest priority.
          ptr   <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: directed timing, burst, contention
// and reset scenarios plus randomized rounds against a round-robin model.
module tb_spi_arbiter;

  localparam int N  = 4;
  localparam int BW = 8;
  localparam int LW = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [N-1:0]      req;
  logic [N*LW-1:0]   req_len;
  logic [N*BW-1:0]   req_data;
  logic [N-1:0]      data_ack;
  logic [BW-1:0]     rsp_data;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      cs_n;
  logic              busy;
  logic [1:0]        grant_id;
  logic [BW-1:0]     m_data_in;
  logic              m_tx_start;
  logic              m_tx_done;
  logic [BW-1:0]     m_data_out;
  logic              err;
  logic              m_abort_n;

  spi_arbiter #(
    .NUM_REQ  (N),
    .BITS_SIZE(BW),
    .LEN_W    (LW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_len   (req_len),
    .req_data  (req_data),
    .data_ack  (data_ack),
    .rsp_data  (rsp_data),
    .rsp_valid (rsp_valid),
    .cs_n      (cs_n),
    .busy      (busy),
    .grant_id  (grant_id),
    .m_data_in (m_data_in),
    .m_tx_start(m_tx_start),
    .m_tx_done (m_tx_done),
    .m_data_out(m_data_out),
    .err       (err),
    .m_abort_n (m_abort_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-requester transmit script and progress.
  logic [7:0] tx_bytes [N][16];
  int         tx_len   [N];
  int         tx_pos   [N];
  int         ack_cnt  [N];
  bit         drop_on_ack = 1'b1;

  // Observed grant order and received responses.
  int         grant_log [$];
  int         rsp_idx   [$];
  logic [7:0] rsp_dat   [$];
  logic [N-1:0] prev_cs_n = '1;

  int         model_ptr = 0;
  logic [7:0] mb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First requester at or after p, wrapping; -1 when none pending.
  function automatic int rr_pick(input logic [N-1:0] pend, input int p);
    for (int k = 0; k < N; k++)
      if (pend[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic fill_random(input int i, input int len);
    for (int k = 0; k <= len; k++) tx_bytes[i][k] = 8'($urandom);
  endtask

  task automatic load_req(input int i, input int len);
    tx_len[i]  = len;
    tx_pos[i]  = 0;
    ack_cnt[i] = 0;
    req_data[i*BW +: BW] = tx_bytes[i][0];
    req_len[i*LW +: LW]  = LW'(len);
  endtask

  // One cycle: sample at the falling edge, log events, act as the requesters.
  task automatic tick();
    logic [N-1:0] sel;
    @(negedge clk);
    sel = ~cs_n;
    check("cs_onehot", 32'($countones(sel) <= 1), 32'd1);
    if (cs_n != prev_cs_n && cs_n != {N{1'b1}}) begin
      for (int i = 0; i < N; i++)
        if (!cs_n[i]) begin
          grant_log.push_back(i);
          check("grant_id", grant_id, i);
        end
    end
    prev_cs_n = cs_n;
    if (rsp_valid != '0) begin
      check("rsp_valid_sel", rsp_valid, sel);
      for (int i = 0; i < N; i++)
        if (rsp_valid[i]) begin
          rsp_idx.push_back(i);
          rsp_dat.push_back(rsp_data);
        end
    end
    if (data_ack != '0) begin
      check("ack_sel", data_ack, sel);
      for (int i = 0; i < N; i++)
        if (data_ack[i]) begin
          ack_cnt[i]++;
          tx_pos[i]++;
          req_data[i*BW +: BW] = (tx_pos[i] <= tx_len[i]) ? tx_bytes[i][tx_pos[i]] : 8'($urandom);
          req_len[i*LW +: LW]  = LW'($urandom);
          if (drop_on_ack) req[i] = 1'b0;
        end
    end
  endtask

  task automatic clear_logs();
    grant_log.delete();
    rsp_idx.delete();
    rsp_dat.delete();
  endtask

  task automatic wait_round(input int n_exp);
    for (int c = 0; c < 1500; c++) begin
      if (grant_log.size() >= n_exp && !busy && m_tx_done) break;
      tick();
    end
    check("end_busy", busy, 0);
    check("end_cs_n", cs_n, {N{1'b1}});
  endtask

  // Raise all requesters in mask at once, each dropping req on its first
  // byte; compare grant order, ack counts and loopback bytes to the model.
  task automatic run_round(input logic [N-1:0] mask);
    int order [$];
    logic [N-1:0] pend;
    int g;
    int k;
    clear_logs();
    pend = mask;
    while (pend != '0) begin
      g = rr_pick(pend, model_ptr);
      order.push_back(g);
      pend[g] = 1'b0;
      model_ptr = (g + 1) % N;
    end
    req = mask;
    wait_round(order.size());
    check("n_grants", grant_log.size(), order.size());
    for (int j = 0; j < order.size() && j < grant_log.size(); j++)
      check("grant_order", grant_log[j], order[j]);
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        check("ack_count", ack_cnt[i], tx_len[i] + 1);
        k = 0;
        for (int j = 0; j < rsp_idx.size(); j++)
          if (rsp_idx[j] == i) begin
            if (k <= tx_len[i]) check("rx_byte", rsp_dat[j], tx_bytes[i][k]);
            k++;
          end
        check("rsp_count", k, tx_len[i] + 1);
      end
    end
  endtask

  // SPI master with slave loopback: clears done on the start edge, returns
  // the transmitted byte after a random latency.
  initial begin
    m_tx_done  = 1'b1;
    m_data_out = '0;
    forever begin
      @(negedge clk);
      if (m_tx_start === 1'b1) begin
        mb = m_data_in;
        @(posedge clk);
        #1 m_tx_done = 1'b0;
        m_data_out = 8'($urandom);
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1 m_data_out = mb;
        m_tx_done = 1'b1;
      end
    end
  end

  initial begin
    int len;
    logic [N-1:0] mask;
    req      = '0;
    req_len  = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      tx_len[i] = 0; tx_pos[i] = 0; ack_cnt[i] = 0;
    end

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 4'hF);
    check("rst_busy", busy, 0);
    check("rst_data_ack", data_ack, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_tx_start", m_tx_start, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_m_data_in", m_data_in, 0);
    check("rst_err", err, 0);
    check("rst_abort_n", m_abort_n, 1);
    #2 reset_n = 1'b1;

    // Contention: all requesters held, pointer 0 -> 0,1,2,3,0.
    drop_on_ack = 1'b0;
    clear_logs();
    for (int i = 0; i < N; i++) begin
      fill_random(i, 0);
      load_req(i, 0);
    end
    req = '1;
    for (int c = 0; c < 600 && grant_log.size() < 5; c++) tick();
    req = '0;
    wait_round(5);
    drop_on_ack = 1'b1;
    check("cont_n_grants", grant_log.size(), 5);
    for (int j = 0; j < 5; j++) begin
      int g;
      g = rr_pick('1, model_ptr);
      model_ptr = (g + 1) % N;
      if (j < grant_log.size()) check("cont_order", grant_log[j], g);
    end

    // Single requester 1, one byte 0xA5, cycle-exact timing.
    clear_logs();
    tx_bytes[1][0] = 8'hA5;
    load_req(1, 0);
    req = 4'b0010;
    tick();
    check("t1_cs_n", cs_n, 4'b1101);
    check("t1_busy", busy, 1);
    check("t1_ack", data_ack, 0);
    tick();
    check("t2_ack", data_ack, 4'b0010);
    check("t2_m_data_in", m_data_in, 8'hA5);
    check("t2_tx_start", m_tx_start, 0);
    tick();
    check("t3_tx_start", m_tx_start, 1);
    check("t3_ack", data_ack, 0);
    for (int c = 0; c < 50 && rsp_valid == '0; c++) tick();
    check("single_rsp_valid", rsp_valid, 4'b0010);
    check("single_rsp_data", rsp_data, 8'hA5);
    check("single_cs_hold", cs_n, 4'b1101);
    tick();
    check("single_cs_release", cs_n, 4'hF);
    check("single_busy_low", busy, 0);
    check("single_ack_count", ack_cnt[1], 1);
    model_ptr = (rr_pick(4'b0010, model_ptr) + 1) % N;

    // Four-byte burst on requester 2.
    tx_bytes[2][0] = 8'h11; tx_bytes[2][1] = 8'h22;
    tx_bytes[2][2] = 8'h33; tx_bytes[2][3] = 8'h44;
    load_req(2, 3);
    run_round(4'b0100);

    // Requester 0 drops req after its first byte; all three bytes still go.
    fill_random(0, 2);
    load_req(0, 2);
    run_round(4'b0001);

    // Randomized rounds.
    for (int r = 0; r < 25; r++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        if (mask[i]) begin
          len = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
          fill_random(i, len);
          load_req(i, len);
        end
      run_round(mask);
    end

    // Reset mid-burst: move the pointer to 2, then abort a burst of 2.
    fill_random(1, 0);
    load_req(1, 0);
    run_round(4'b0010);
    fill_random(2, 3);
    load_req(2, 3);
    req = 4'b0100;
    for (int c = 0; c < 20 && m_tx_start !== 1'b1; c++) tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("arst_cs_n", cs_n, 4'hF);
    check("arst_busy", busy, 0);
    check("arst_grant_id", grant_id, 0);
    check("arst_tx_start", m_tx_start, 0);
    req = '0;
    repeat (2) tick();
    for (int c = 0; c < 20 && !m_tx_done; c++) tick();
    #2 reset_n = 1'b1;
    model_ptr = 0;
    fill_random(1, 1);
    load_req(1, 1);
    fill_random(2, 0);
    load_req(2, 0);
    run_round(4'b0110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
